// File: rtl/posit_defines.sv
// Shared posit definitions: field-width profile type and output width helpers.
package posit_defines;

    // Field-width profile: NORMAL keeps every fraction bit a posit can carry,
    // COMPACT keeps only the upper half of them.
    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        COMPACT = 1'b1
    } pd_type;

    // Signed width holding k*2^ES + e over the whole regime range.
    function automatic int unsigned get_scale_width(input int unsigned n,
                                                    input int unsigned es,
                                                    input pd_type      t);
        int unsigned w;
        w = $clog2((n - 1) << es) + 1;
        case (t)
            NORMAL:  return w;
            default: return w;
        endcase
    endfunction

    // Fraction width: the widest fraction occurs with a 2-bit regime.
    function automatic int unsigned get_fraction_width(input int unsigned n,
                                                       input int unsigned es,
                                                       input pd_type      t);
        int unsigned w;
        w = (n > es + 3) ? (n - es - 3) : 1;
        case (t)
            COMPACT: return (w > 1) ? (w / 2) : 1;
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/posit_regime_counter.sv
// Combinational regime run-length counter over the bits below the sign.
module posit_regime_counter
    import posit_defines::*;
#(
    parameter  int unsigned POSIT_WIDTH = 32,
    localparam int unsigned MW          = $clog2(POSIT_WIDTH)
) (
    input  logic [POSIT_WIDTH-2:0] bits_i,
    output logic [MW-1:0]          m_o,
    output logic                   r_o
);

    localparam int unsigned W = POSIT_WIDTH - 1;

    logic run;

    // Count leading bits equal to the MSB; the first differing bit ends the run.
    always_comb begin
        r_o = bits_i[W-1];
        m_o = '0;
        run = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            if (run && (bits_i[W-1-i] == r_o)) begin
                m_o = m_o + MW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/posit_decode_stream.sv
// Two-stage streaming posit decoder: sign/abs/regime, then exponent/fraction.
module posit_decode_stream
    import posit_defines::*;
#(
    parameter  int unsigned POSIT_WIDTH = 32,
    parameter  int unsigned POSIT_ES    = 2,
    parameter  pd_type      PD_TYPE     = NORMAL,
    localparam int unsigned SW = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE),
    localparam int unsigned FW = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [POSIT_WIDTH-1:0] posit_word_i,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   sign,
    output logic signed [SW-1:0]   scale,
    output logic [FW-1:0]          fraction,
    output logic                   zero,
    output logic                   NaR
);

    localparam int unsigned AW = POSIT_WIDTH - 1;
    localparam int unsigned MW = $clog2(POSIT_WIDTH);
    localparam int unsigned TW = POSIT_ES + FW;
    localparam int unsigned XW = AW + TW;

    logic                   ready_en_q, ready_en_d;
    logic                   v1_q, v1_d, v2_q, v2_d;
    logic                   sign1_q, sign1_d, zero1_q, zero1_d, nar1_q, nar1_d, r1_q, r1_d;
    logic [AW-1:0]          abs1_q, abs1_d;
    logic [MW-1:0]          m1_q, m1_d;
    logic                   sign_q, sign_d, zero_q, zero_d, nar_q, nar_d;
    logic signed [SW-1:0]   scale_q, scale_d;
    logic [FW-1:0]          fraction_q, fraction_d;

    logic                   ld1, ld2, take;
    logic [POSIT_WIDTH-1:0] abs_word;
    logic [MW-1:0]          m_cnt;
    logic                   r_cnt;
    logic [XW-1:0]          shifted;
    logic [TW-1:0]          top;
    logic [31:0]            e_val;
    logic signed [31:0]     k_val, scale_full;

    assign abs_word = posit_word_i[POSIT_WIDTH-1] ? (~posit_word_i + 1'b1) : posit_word_i;

    posit_regime_counter #(
        .POSIT_WIDTH(POSIT_WIDTH)
    ) u_regime (
        .bits_i(abs_word[AW-1:0]),
        .m_o   (m_cnt),
        .r_o   (r_cnt)
    );

    // Plain logical shift past regime and terminator; bits shifted beyond the word read as zero.
    assign shifted = {abs1_q, {TW{1'b0}}} << ({1'b0, m1_q} + (MW+1)'(1));
    assign top     = TW'(shifted >> AW);

    if (POSIT_ES > 0) begin : g_exp
        assign e_val = 32'(top[FW +: POSIT_ES]);
    end else begin : g_noexp
        assign e_val = '0;
    end

    assign k_val      = r1_q ? ($signed(32'(m1_q)) - 32'sd1) : -$signed(32'(m1_q));
    assign scale_full = (k_val <<< POSIT_ES) + $signed(e_val);

    // Handshake: ready is withheld until the first clock after reset release.
    assign ld2     = ~v2_q | m_ready;
    assign ld1     = ready_en_q & (~v1_q | ld2);
    assign take    = s_valid & ld1;
    assign s_ready = ld1;

    // Next-state for both pipeline stages; data only moves alongside a valid word.
    always_comb begin
        ready_en_d = 1'b1;
        v1_d       = v1_q;
        sign1_d    = sign1_q;
        abs1_d     = abs1_q;
        zero1_d    = zero1_q;
        nar1_d     = nar1_q;
        m1_d       = m1_q;
        r1_d       = r1_q;
        v2_d       = v2_q;
        sign_d     = sign_q;
        scale_d    = scale_q;
        fraction_d = fraction_q;
        zero_d     = zero_q;
        nar_d      = nar_q;
        if (ld1) begin
            v1_d = s_valid;
        end
        if (take) begin
            sign1_d = posit_word_i[POSIT_WIDTH-1];
            abs1_d  = abs_word[AW-1:0];
            zero1_d = (posit_word_i == '0);
            nar1_d  = posit_word_i[POSIT_WIDTH-1] && (posit_word_i[AW-1:0] == '0);
            m1_d    = m_cnt;
            r1_d    = r_cnt;
        end
        if (ld2) begin
            v2_d = v1_q;
        end
        if (ld2 && v1_q) begin
            sign_d     = sign1_q;
            zero_d     = zero1_q;
            nar_d      = nar1_q;
            scale_d    = (zero1_q || nar1_q) ? '0 : SW'(scale_full);
            fraction_d = (zero1_q || nar1_q) ? '0 : top[FW-1:0];
        end
    end

    // Pipeline registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            v1_q       <= 1'b0;
            sign1_q    <= 1'b0;
            abs1_q     <= '0;
            zero1_q    <= 1'b0;
            nar1_q     <= 1'b0;
            m1_q       <= '0;
            r1_q       <= 1'b0;
            v2_q       <= 1'b0;
            sign_q     <= 1'b0;
            scale_q    <= '0;
            fraction_q <= '0;
            zero_q     <= 1'b0;
            nar_q      <= 1'b0;
        end else begin
            ready_en_q <= ready_en_d;
            v1_q       <= v1_d;
            sign1_q    <= sign1_d;
            abs1_q     <= abs1_d;
            zero1_q    <= zero1_d;
            nar1_q     <= nar1_d;
            m1_q       <= m1_d;
            r1_q       <= r1_d;
            v2_q       <= v2_d;
            sign_q     <= sign_d;
            scale_q    <= scale_d;
            fraction_q <= fraction_d;
            zero_q     <= zero_d;
            nar_q      <= nar_d;
        end
    end

    assign m_valid  = v2_q;
    assign sign     = sign_q;
    assign scale    = scale_q;
    assign fraction = fraction_q;
    assign zero     = zero_q;
    assign NaR      = nar_q;

endmodule
